// File: rtl/pokemon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : pokemon_pkg                                                     |
// | Shared types and default constants for the character sprite read path:  |
// | facing direction, default sprite-sheet geometry and bus widths.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package pokemon_pkg;

  // Sheet row order is DOWN, UP, LEFT, RIGHT; the value doubles as the
  // direction block index in the sprite RAM.
  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int C_SPR_W      = 16;
  localparam int C_SPR_H      = 20;
  localparam int C_FRAMES     = 4;
  localparam int C_SCALE_LOG2 = 1;
  localparam int C_ANIM_DIV   = 8;
  localparam int C_TRANSP_IDX = 0;

  localparam int C_ADDR_W  = 19;
  localparam int C_COORD_W = 10;
  localparam int C_PIX_W   = 5;

  // Counter width that stays legal when the modulus is 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sprite_anim_ctr                                                 |
// | Walk-cycle animation counter. Counts frame ticks and advances the walk   |
// | frame once every ANIM_DIV ticks while the player is moving.              |
// | Ports   : Clk, Reset_n (async, active-low), frame_tick (1-cycle pulse),  |
// |           moving (player walking), walk_frame (current walk frame).      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sprite_anim_ctr
  import pokemon_pkg::*;
#(
  parameter int FRAMES   = C_FRAMES,
  parameter int ANIM_DIV = C_ANIM_DIV,
  parameter int FRAME_W  = clog2_min1(C_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               moving,
  output logic [FRAME_W-1:0] walk_frame
);

  localparam int TICK_W = clog2_min1(ANIM_DIV);

  logic [TICK_W-1:0]  r_tick_cnt;
  logic [FRAME_W-1:0] r_walk_frame;

  // Standing still parks the animation on frame 0; the moving value sampled
  // on a tick edge is the one that governs that tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tick_cnt   <= '0;
      r_walk_frame <= '0;
    end else if (!moving) begin
      r_tick_cnt   <= '0;
      r_walk_frame <= '0;
    end else if (frame_tick) begin
      if (r_tick_cnt == TICK_W'(ANIM_DIV - 1)) begin
        r_tick_cnt   <= '0;
        r_walk_frame <= (r_walk_frame == FRAME_W'(FRAMES - 1)) ? '0
                                                               : r_walk_frame + FRAME_W'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
    end
  end

  assign walk_frame = r_walk_frame;

endmodule
`default_nettype wire

// File: rtl/character_sprite_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : character_sprite_reader                                         |
// | Per-pixel read engine for the character sprite RAM. Converts the beam   |
// | position and the frame-latched player state into a sprite-RAM address,  |
// | then returns the fetched palette index with a visibility flag, three    |
// | cycles after the beam position is presented.                            |
// | Ports   : Clk, Reset_n (async, active-low), frame_tick,                 |
// |           DrawX/DrawY (beam), CharX/CharY (sprite top-left),            |
// |           dir_in (facing), moving, read_address -> RAM,                 |
// |           ram_data <- RAM (1-cycle registered read),                    |
// |           pixel_idx / pixel_valid -> colour mapper.                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module character_sprite_reader
  import pokemon_pkg::*;
#(
  parameter int SPR_W      = C_SPR_W,
  parameter int SPR_H      = C_SPR_H,
  parameter int FRAMES     = C_FRAMES,
  parameter int SCALE_LOG2 = C_SCALE_LOG2,
  parameter int ANIM_DIV   = C_ANIM_DIV,
  parameter int TRANSP_IDX = C_TRANSP_IDX
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic [C_COORD_W-1:0] DrawX,
  input  logic [C_COORD_W-1:0] DrawY,
  input  logic [C_COORD_W-1:0] CharX,
  input  logic [C_COORD_W-1:0] CharY,
  input  dir_t                 dir_in,
  input  logic                 moving,
  output logic [C_ADDR_W-1:0]  read_address,
  input  logic [C_PIX_W-1:0]   ram_data,
  output logic [C_PIX_W-1:0]   pixel_idx,
  output logic                 pixel_valid
);

  localparam int FRAME_W = clog2_min1(FRAMES);
  // On-screen sprite extent; compared at 11 bits so a sprite hanging off the
  // right or bottom edge clips rather than wrapping to column/row 0.
  localparam logic [C_COORD_W:0] C_W_PIX = (C_COORD_W + 1)'(SPR_W << SCALE_LOG2);
  localparam logic [C_COORD_W:0] C_H_PIX = (C_COORD_W + 1)'(SPR_H << SCALE_LOG2);

  logic [C_COORD_W-1:0] r_sx;
  logic [C_COORD_W-1:0] r_sy;
  dir_t                 r_dir;

  logic [C_ADDR_W-1:0]  r_read_address;
  logic                 r_hit_d1;
  logic                 r_hit_d2;
  logic [C_PIX_W-1:0]   r_pixel_idx;
  logic                 r_pixel_valid;

  logic [FRAME_W-1:0]   w_walk_frame;
  logic                 w_x_ge;
  logic                 w_y_ge;
  logic [C_COORD_W:0]   w_dx;
  logic [C_COORD_W:0]   w_dy;
  logic                 w_hit;
  logic [C_ADDR_W-1:0]  w_col;
  logic [C_ADDR_W-1:0]  w_row;
  logic [C_ADDR_W-1:0]  w_sheet;
  logic [C_ADDR_W-1:0]  w_addr_calc;
  logic [C_ADDR_W-1:0]  w_addr;
  logic                 w_valid_next;

  sprite_anim_ctr #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV),
    .FRAME_W  (FRAME_W)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .moving     (moving),
    .walk_frame (w_walk_frame)
  );

  // Position and facing are sampled once per frame so a mid-frame update
  // from game logic cannot tear the sprite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_dir <= DOWN;
    end else if (frame_tick) begin
      r_sx  <= CharX;
      r_sy  <= CharY;
      r_dir <= dir_in;
    end
  end

  // Hit test: offsets are only meaningful once the beam is at or past the
  // sprite origin, so they are forced to zero otherwise.
  always_comb begin
    w_x_ge = (DrawX >= r_sx);
    w_y_ge = (DrawY >= r_sy);
    w_dx   = w_x_ge ? ({1'b0, DrawX} - {1'b0, r_sx}) : '0;
    w_dy   = w_y_ge ? ({1'b0, DrawY} - {1'b0, r_sy}) : '0;
    w_hit  = w_x_ge && w_y_ge && (w_dx < C_W_PIX) && (w_dy < C_H_PIX);
  end

  // Sheet layout: direction blocks of FRAMES frames, each SPR_H rows of
  // SPR_W texels. All multipliers are elaboration-time constants.
  always_comb begin
    w_col       = C_ADDR_W'(w_dx >> SCALE_LOG2);
    w_row       = C_ADDR_W'(w_dy >> SCALE_LOG2);
    w_sheet     = C_ADDR_W'(r_dir) * C_ADDR_W'(FRAMES) + C_ADDR_W'(w_walk_frame);
    w_addr_calc = (w_sheet * C_ADDR_W'(SPR_H) + w_row) * C_ADDR_W'(SPR_W) + w_col;
    w_addr      = w_hit ? w_addr_calc : '0;
  end

  assign w_valid_next = r_hit_d2 && (ram_data != C_PIX_W'(TRANSP_IDX));

  // Stage 1 drives the RAM address; the RAM supplies stage 2; stage 3
  // qualifies the returned index with the delayed hit flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_read_address <= '0;
      r_hit_d1       <= 1'b0;
      r_hit_d2       <= 1'b0;
      r_pixel_idx    <= '0;
      r_pixel_valid  <= 1'b0;
    end else begin
      r_read_address <= w_addr;
      r_hit_d1       <= w_hit;
      r_hit_d2       <= r_hit_d1;
      r_pixel_valid  <= w_valid_next;
      r_pixel_idx    <= w_valid_next ? ram_data : '0;
    end
  end

  assign read_address = r_read_address;
  assign pixel_idx    = r_pixel_idx;
  assign pixel_valid  = r_pixel_valid;

endmodule
`default_nettype wire

// File: tb/tb_character_sprite_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_character_sprite_reader                                      |
// | Directed self-checking bench for character_sprite_reader with a         |
// | behavioural 1-cycle registered sprite RAM.                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_character_sprite_reader;
  import pokemon_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic [9:0]  DrawX, DrawY, CharX, CharY;
  dir_t        dir_in;
  logic        moving;
  logic [18:0] read_address;
  logic [4:0]  ram_data;
  logic [4:0]  pixel_idx;
  logic        pixel_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] mem [0:8191];

  character_sprite_reader dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .CharX        (CharX),
    .CharY        (CharY),
    .dir_in       (dir_in),
    .moving       (moving),
    .read_address (read_address),
    .ram_data     (ram_data),
    .pixel_idx    (pixel_idx),
    .pixel_valid  (pixel_valid)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM: registered read, contents mem[a] = (a % 30) + 1 unless
  // overridden below.
  always @(posedge Clk) ram_data <= mem[read_address[12:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic park();
    DrawX = 10'd0;
    DrawY = 10'd479;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  // Present one beam pixel, check the address after edge 1, that nothing
  // shows at edge 2, and the qualified index after edge 3.
  task automatic pix(input string tag, input int x, input int y,
                     input logic [18:0] ea, input logic ev, input logic [4:0] ei);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk); #1;
    check({tag, " addr"}, 32'(read_address), 32'(ea));
    park();
    @(posedge Clk); #1;
    check({tag, " early"}, 32'(pixel_valid), 32'd0);
    @(posedge Clk); #1;
    check({tag, " valid"}, 32'(pixel_valid), 32'(ev));
    check({tag, " idx"}, 32'(pixel_idx), 32'(ei));
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 5'((a % 30) + 1);
    mem[0] = 5'd7;
    mem[5] = 5'd0;           // transparent texel

    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    CharX      = 10'd100;
    CharY      = 10'd50;
    dir_in     = DOWN;
    moving     = 1'b0;
    park();

    repeat (3) @(posedge Clk);
    #1;
    check("rst addr", 32'(read_address), 32'd0);
    check("rst idx", 32'(pixel_idx), 32'd0);
    check("rst valid", 32'(pixel_valid), 32'd0);
    Reset_n = 1'b1;

    // Basic hits/misses, scale 2, DOWN frame 0
    tick(1);
    pix("origin", 100, 50, 19'd0, 1'b1, 5'd7);
    pix("last", 131, 89, 19'd319, 1'b1, 5'd20);
    pix("right_miss", 132, 50, 19'd0, 1'b0, 5'd0);
    pix("left_miss", 99, 50, 19'd0, 1'b0, 5'd0);
    pix("above_miss", 100, 49, 19'd0, 1'b0, 5'd0);
    pix("bottom_miss", 100, 90, 19'd0, 1'b0, 5'd0);
    pix("texel00b", 101, 51, 19'd0, 1'b1, 5'd7);
    pix("texel11", 102, 52, 19'd17, 1'b1, 5'd18);
    pix("transp", 110, 50, 19'd5, 1'b0, 5'd0);

    // Walk animation facing RIGHT
    dir_in = RIGHT;
    moving = 1'b1;
    tick(7);
    pix("walk7", 100, 50, 19'd3840, 1'b1, 5'd1);
    tick(1);
    pix("walk8", 100, 50, 19'd4160, 1'b1, 5'd21);
    tick(24);
    pix("walk32", 100, 50, 19'd3840, 1'b1, 5'd1);
    tick(8);
    pix("walk40", 100, 50, 19'd4160, 1'b1, 5'd21);
    moving = 1'b0;
    tick(1);
    pix("stop", 100, 50, 19'd3840, 1'b1, 5'd1);

    // Position changes only take effect at a frame tick
    CharX = 10'd200;
    pix("nolatch_old", 100, 50, 19'd3840, 1'b1, 5'd1);
    pix("nolatch_new", 200, 50, 19'd0, 1'b0, 5'd0);
    tick(1);
    pix("latch_new", 200, 50, 19'd3840, 1'b1, 5'd1);
    pix("latch_old", 100, 50, 19'd0, 1'b0, 5'd0);

    // Right-edge clipping, no wrap to x=0
    CharX = 10'd620;
    tick(1);
    pix("clip_hit", 639, 50, 19'd3849, 1'b1, 5'd10);
    pix("clip_nowrap", 0, 50, 19'd0, 1'b0, 5'd0);
    pix("clip_left", 619, 50, 19'd0, 1'b0, 5'd0);

    // Reach walk frame 2, then reset mid-line
    moving = 1'b1;
    tick(16);
    DrawX = 10'd639;
    DrawY = 10'd50;
    @(posedge Clk); #1;
    check("pre_rst addr", 32'(read_address), 32'd4489);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("pre_rst valid", 32'(pixel_valid), 32'd1);
    check("pre_rst idx", 32'(pixel_idx), 32'd20);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async addr", 32'(read_address), 32'd0);
    check("async valid", 32'(pixel_valid), 32'd0);
    check("async idx", 32'(pixel_idx), 32'd0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("held addr", 32'(read_address), 32'd0);
    check("held valid", 32'(pixel_valid), 32'd0);
    moving = 1'b0;
    park();
    Reset_n = 1'b1;

    // Shadows back at 0,0 facing DOWN, walk frame 0, no tick since reset
    pix("post_rst0", 0, 0, 19'd0, 1'b1, 5'd7);
    pix("post_rst_last", 31, 39, 19'd319, 1'b1, 5'd20);
    pix("post_rst_miss", 32, 0, 19'd0, 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/character_sprite_reader.md
# character_sprite_reader

Read-side engine for the character sprite RAM. It sits between the VGA controller and the colour mapper. Per pixel it turns the beam position (DrawX, DrawY), the player's latched screen position, facing direction and walk-animation frame into a sprite-RAM read address. It then returns the fetched palette index with a hit/transparency flag, aligned to a fixed pipeline latency. It also owns the walk-cycle animation counter, which advances on vertical-sync frame ticks.

## Interface
- SPR_W, 16, sprite width in texels
- SPR_H, 20, sprite height in texels
- FRAMES, 4, walk frames per direction
- SCALE_LOG2, 1, on-screen magnification (texel = 2^SCALE_LOG2 pixels square)
- ANIM_DIV, 8, frame ticks per walk-frame advance
- TRANSP_IDX, 0, palette index treated as transparent

- Clk  in  1  system clock (pixel-rate domain)
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- DrawX, DrawY  in  10 each  current beam pixel
- CharX, CharY  in  10 each  requested sprite top-left (screen pixels)
- dir_in  in  2  requested facing (dir_t)
- moving  in  1  player walking
- read_address  out  19  to sprite RAM read port
- ram_data  in  5  sprite RAM data_Out (1-cycle registered read)
- pixel_idx  out  5  palette index for the colour mapper
- pixel_valid  out  1  beam inside sprite and index != TRANSP_IDX

## Operation
- Frame latch: on frame_tick, capture CharX, CharY and dir_in into shadow registers. All address math uses the shadows only, so a frame never tears.
- Animation counter: tick_cnt counts frame_ticks from 0 to ANIM_DIV-1. On wrap with moving=1, walk_frame increments mod FRAMES. While moving=0, tick_cnt and walk_frame are held at 0. A direction change does not reset walk_frame.
- Hit test uses 11-bit unsigned arithmetic: dx = DrawX - sx and dy = DrawY - sy, both computed only when DrawX >= sx and DrawY >= sy. hit = those guards AND dx < SPR_W<<SCALE_LOG2 AND dy < SPR_H<<SCALE_LOG2.
- Texel coordinates: col = dx >> SCALE_LOG2, row = dy >> SCALE_LOG2.
- Address = ((dir*FRAMES + walk_frame)*SPR_H + row)*SPR_W + col, zero-extended to 19 bits. Sheet order is DOWN, UP, LEFT, RIGHT, frames contiguous. With defaults the highest address is 5119.
- On a miss, read_address is driven to 0 (don't-care data) and the hit flag is carried as 0.
- A sprite that is partially off-screen right or bottom simply clips. Nothing wraps, because the compare is done at 11 bits.

## Timing
- Latency from DrawX/DrawY to pixel_idx/pixel_valid is 3 cycles.
  - Edge 1: register read_address and hit_d1.
  - Edge 2: RAM registers ram_data; hit_d2 <= hit_d1.
  - Edge 3: pixel_idx <= ram_data; pixel_valid <= hit_d2 && ram_data != TRANSP_IDX.
- The downstream blanking and sync pipeline must delay by 3 to match.
- When pixel_valid=0, pixel_idx is forced to 0.
- frame_tick coincident with wrap: the shadow latch and walk_frame update on the same edge, so the new frame uses both.
- frame_tick while moving falls on the same edge: the new moving value governs that tick.
- Reset state, held during Reset_n=0:
  - read_address=0, pixel_idx=0, pixel_valid=0.
  - Shadows: sx=sy=0, dir=DOWN.
  - tick_cnt=0, walk_frame=0, hit pipeline cleared.
- Reset released mid-line: the first valid output appears 3 cycles after the first post-reset edge.

## Structure
- pokemon_pkg holds dir_t (DOWN=0, UP=1, LEFT=2, RIGHT=3), the default sprite dimension constants, and the address width constant (19).
- Sub-module sprite_anim_ctr: frame_tick, moving in; walk_frame out. It holds tick_cnt and walk_frame with the same async reset.
- The address multiply uses constant parameters only, so synthesis reduces it to adders/shifts. No runtime multiplier.

## Test plan
- Reset, then CharX=100, CharY=50, dir=DOWN, frame_tick, beam at (100,50) -> read_address=0 one cycle later; ram_data=7 -> pixel_idx=7, pixel_valid=1 exactly 3 cycles after the beam input.
- Same setup, beam at (131,89) (last pixel, scale 2) -> address 319. Beam at (132,50) and at (99,50) -> pixel_valid=0.
- dir=RIGHT, moving=1, 8 frame_ticks: walk_frame=1 and the address for beam (100,50) is (3*4+1)*320 = 4160. After 32 ticks walk_frame wraps to 0.
- Change CharX to 200 mid-frame with no frame_tick -> hits stay at x=100. After the next frame_tick, hits move to x=200.
- ram_data=TRANSP_IDX inside the sprite -> pixel_valid=0, pixel_idx=0. CharX=620 with beam at 639 -> hit. DrawX cannot exceed 639, so no wrap hit at x=0.
- Assert Reset_n low mid-line with walk_frame=2 -> all outputs 0 immediately (asynchronous), walk_frame=0, dir=DOWN.
